alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode/issue pipeline stage that drives the integer ALU. It takes a 32-bit RV32 instruction with its already-read register operands and produces the ALU command: operand A, operand B and the 4-bit ALU control code. It also produces writeback/memory sidebands and a one-cycle illegal-instruction pulse. It sits between register read and execute, with a valid/ready handshake on each side and a 2-entry skid buffer.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept; equals !skid_valid.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction address.
- in_rs1_data, in_rs2_data  in  32 each  register file read data.
- flush  in  1  discard all held beats and any beat presented this cycle.
- out_valid  out  1  command valid.
- out_ready  in  1  execute stage accepts.
- op_a, op_b  out  32 each  ALU operands.
- alu_control  out  4  ALU op code: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT, 1000 SLL, 1001 SRL, 1010 SRA.
- rd  out  5  destination register; 0 when rd_we=0.
- rd_we  out  1  writeback enable.
- is_load, is_store  out  1 each  memory op flags; the ALU result is the address.
- mem_funct3  out  3  inst[14:12] for memory ops, else 0.
- store_data  out  32  rs2 data for stores, else 0.
- illegal  out  1  one-cycle pulse on an accepted illegal instruction.
- illegal_inst  out  32  last illegal instruction word; holds its value.

## Operation
**Decode (combinational on the input beat)**
- Opcode 0110011, funct7 0000000: funct3 000 ADD, 001 SLL, 100 XOR, 101 SRL, 110 OR, 111 AND.
- Opcode 0110011, funct7 0100000: funct3 000 SUB, 101 SRA.
- Opcode 0110011, funct7 0000001: funct3 000 MUL, 100 DIV.
- For these R-type ops: A=rs1, B=rs2.
- Opcode 0010011, A=rs1, B=sext(inst[31:20]):
  - funct3 000 ADD, 100 XOR, 110 OR, 111 AND.
  - funct3 001 SLL, only if inst[31:25]=0.
  - funct3 101: SRL if inst[31:25]=0000000, SRA if 0100000.
  - For shift immediates, B is zero-extended inst[24:20].
- Load (0000011), funct3 in {000,001,010,100,101}: ADD, A=rs1, B=sext(inst[31:20]), is_load=1.
- Store (0100011), funct3 in {000,001,010}: ADD, A=rs1, B=sext({inst[31:25],inst[11:7]}), is_store=1, store_data=rs2, rd_we=0.
- LUI (0110111): ADD, A=0, B={inst[31:12],12'b0}.
- AUIPC (0010111): ADD, A=in_pc, B={inst[31:12],12'b0}.
- rd_we=1 for every legal non-store op with inst[11:7]≠0.
- Every other encoding is illegal, including SLT/SLTU, MULH*, DIVU, REM* and all branches and jumps.
- Codes 0111 (NOT) are never emitted.

**Buffering**
- Main entry drives the out_* ports. The skid entry holds one extra beat.
- Accept = in_valid & in_ready & !flush.
- A legal accepted beat goes to main if main is empty or draining this cycle (out_valid&out_ready); otherwise it goes to skid.
- When main drains and skid is valid, skid moves to main in the same edge. Order is always preserved.
- An illegal accepted beat completes the handshake but is never buffered. illegal=1 on the next cycle and illegal_inst is updated.
- flush=1: main and skid are cleared at the edge, the presented beat is dropped, and no illegal pulse is produced. Flush has priority over every other event.

## Timing
- Reset (rst_n low at an edge):
  - out_valid=0, in_ready=1 the cycle after release.
  - Sideband outputs 0, illegal=0, illegal_inst=0.
  - Beats presented during reset are ignored.
- Latency: accept at edge N gives out_valid=1 after edge N, with all fields stable while out_valid&!out_ready.
- Throughput: 1 beat per cycle with out_ready held high.
- in_ready drops the cycle after skid fills. It rises the cycle after skid moves to main.
- Outputs are fully registered; there is no combinational path from in_* to out_*.
- Reset asserted mid-stall discards both entries, identical to flush.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, op_a=5, op_b=7, alu_control=0000, rd=3, rd_we=1.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> op_b=3, alu_control=1010, rd=5. Then LUI x1,0x12345 (0x123450B7) -> op_a=0, op_b=0x12345000, alu_control=0000.
- SW x2,4(x1) (0x0020A223), rs1=0x100, rs2=0xCAFEF00D -> op_a=0x100, op_b=4, is_store=1, mem_funct3=010, store_data=0xCAFEF00D, rd_we=0, rd=0.
- out_ready=0, three back-to-back ADDs:
  - First two are accepted; in_ready=0 the cycle after the second and the third is held.
  - Raising out_ready delivers beats 1, 2, 3 in order with none lost or duplicated.
- SLT (0x0020A1B3) accepted -> in_ready stays 1, out_valid stays 0, illegal pulses for exactly one cycle, illegal_inst=0x0020A1B3.
- Both entries full, then flush=1 with a valid beat presented -> next cycle out_valid=0, in_ready=1, illegal=0, and the presented beat never appears.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32 decode/issue stage feeding the integer ALU: decodes one instruction per beat
// into an ALU command plus writeback/memory sidebands, behind a 2-entry skid buffer.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [3:0]      alu_control,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            is_load,
    output logic            is_store,
    output logic [2:0]      mem_funct3,
    output logic [XLEN-1:0] store_data,
    output logic            illegal,
    output logic [31:0]     illegal_inst
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [6:0] OPC_REG   = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [3:0]      alu_control;
        logic [4:0]      rd;
        logic            rd_we;
        logic            is_load;
        logic            is_store;
        logic [2:0]      mem_funct3;
        logic [XLEN-1:0] store_data;
    } cmd_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_idx;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rd_idx = in_inst[11:7];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign shamt  = {27'b0, in_inst[24:20]};

    cmd_t dec;
    logic dec_legal;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        dec       = '0;
        dec_legal = 1'b0;
        case (opcode)
            OPC_REG: begin
                dec.op_a  = in_rs1_data;
                dec.op_b  = in_rs2_data;
                dec_legal = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: dec.alu_control = ALU_ADD;
                    10'b0000000_001: dec.alu_control = ALU_SLL;
                    10'b0000000_100: dec.alu_control = ALU_XOR;
                    10'b0000000_101: dec.alu_control = ALU_SRL;
                    10'b0000000_110: dec.alu_control = ALU_OR;
                    10'b0000000_111: dec.alu_control = ALU_AND;
                    10'b0100000_000: dec.alu_control = ALU_SUB;
                    10'b0100000_101: dec.alu_control = ALU_SRA;
                    10'b0000001_000: dec.alu_control = ALU_MUL;
                    10'b0000001_100: dec.alu_control = ALU_DIV;
                    default:         dec_legal       = 1'b0;
                endcase
            end
            OPC_IMM: begin
                dec.op_a  = in_rs1_data;
                dec.op_b  = imm_i;
                dec_legal = 1'b1;
                case (funct3)
                    3'b000: dec.alu_control = ALU_ADD;
                    3'b100: dec.alu_control = ALU_XOR;
                    3'b110: dec.alu_control = ALU_OR;
                    3'b111: dec.alu_control = ALU_AND;
                    3'b001: begin
                        dec.alu_control = ALU_SLL;
                        dec.op_b        = shamt;
                        dec_legal       = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        dec.op_b = shamt;
                        if (funct7 == 7'b0000000)
                            dec.alu_control = ALU_SRL;
                        else if (funct7 == 7'b0100000)
                            dec.alu_control = ALU_SRA;
                        else
                            dec_legal = 1'b0;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.op_a       = in_rs1_data;
                dec.op_b       = imm_i;
                dec.is_load    = 1'b1;
                dec.mem_funct3 = funct3;
                dec_legal      = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                dec.op_a       = in_rs1_data;
                dec.op_b       = imm_s;
                dec.is_store   = 1'b1;
                dec.mem_funct3 = funct3;
                dec.store_data = in_rs2_data;
                dec_legal      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            OPC_LUI: begin
                dec.op_b  = imm_u;
                dec_legal = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op_a  = in_pc;
                dec.op_b  = imm_u;
                dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        dec.rd_we = dec_legal && !dec.is_store && (rd_idx != 5'd0);
        dec.rd    = dec.rd_we ? rd_idx : 5'd0;
    end

    cmd_t main_q;
    cmd_t skid_q;
    logic main_valid;
    logic skid_valid;
    logic accept;
    logic take;

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready && !flush;
    assign take     = accept && dec_legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the payload registers are reset too so every sideband reads 0 out of reset.
            main_valid   <= 1'b0;
            skid_valid   <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
            illegal      <= 1'b0;
            illegal_inst <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            illegal <= accept && !dec_legal;
            if (accept && !dec_legal)
                illegal_inst <= in_inst;

            // A full skid blocks input, so it only ever needs to refill main.
            if (skid_valid) begin
                if (out_ready) begin
                    main_q     <= skid_q;
                    skid_valid <= 1'b0;
                end
            end else if (take) begin
                if (!main_valid || out_ready) begin
                    main_q     <= dec;
                    main_valid <= 1'b1;
                end else begin
                    skid_q     <= dec;
                    skid_valid <= 1'b1;
                end
            end else if (out_ready) begin
                main_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = main_valid;
    assign op_a        = main_q.op_a;
    assign op_b        = main_q.op_b;
    assign alu_control = main_q.alu_control;
    assign rd          = main_q.rd;
    assign rd_we       = main_q.rd_we;
    assign is_load     = main_q.is_load;
    assign is_store    = main_q.is_store;
    assign mem_funct3  = main_q.mem_funct3;
    assign store_data  = main_q.store_data;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized checks of alu_issue_stage against a queue-based model
// of the decode rules and the two-beat holding capacity.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] sd;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_control;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_load;
    logic        is_store;
    logic [2:0]  mem_funct3;
    logic [31:0] store_data;
    logic        illegal;
    logic [31:0] illegal_inst;

    int n_cmp = 0;
    int n_fail = 0;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .alu_control(alu_control), .rd(rd), .rd_we(rd_we),
        .is_load(is_load), .is_store(is_store), .mem_funct3(mem_funct3),
        .store_data(store_data), .illegal(illegal), .illegal_inst(illegal_inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] rs1,
                         input logic [31:0] rs2);
        in_valid    = v;
        in_inst     = inst;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
    endtask

    function automatic cmd_t observed();
        return {op_a, op_b, alu_control, rd, rd_we, is_load, is_store, mem_funct3, store_data};
    endfunction

    // Architectural meaning of each encoding, written straight from the ISA subset rules.
    function automatic bit ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2,
                                      output cmd_t c);
        bit ok;
        int f3;
        int f7;
        int sh;
        int opc;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        opc   = int'(inst[6:0]);
        f3    = int'(inst[14:12]);
        f7    = int'(inst[31:25]);
        sh    = int'(inst[24:20]);
        imm_i = 32'($signed(inst[31:20]));
        imm_s = 32'($signed({inst[31:25], inst[11:7]}));
        c  = '0;
        ok = 1'b0;
        if (opc == 'h33) begin
            c.a = rs1;
            c.b = rs2;
            ok  = 1'b1;
            if (f7 == 0 && f3 == 0) c.ctrl = 4'd0;
            else if (f7 == 0 && f3 == 1) c.ctrl = 4'd8;
            else if (f7 == 0 && f3 == 4) c.ctrl = 4'd6;
            else if (f7 == 0 && f3 == 5) c.ctrl = 4'd9;
            else if (f7 == 0 && f3 == 6) c.ctrl = 4'd5;
            else if (f7 == 0 && f3 == 7) c.ctrl = 4'd4;
            else if (f7 == 'h20 && f3 == 0) c.ctrl = 4'd1;
            else if (f7 == 'h20 && f3 == 5) c.ctrl = 4'd10;
            else if (f7 == 1 && f3 == 0) c.ctrl = 4'd2;
            else if (f7 == 1 && f3 == 4) c.ctrl = 4'd3;
            else ok = 1'b0;
        end else if (opc == 'h13) begin
            c.a = rs1;
            c.b = imm_i;
            ok  = 1'b1;
            if (f3 == 0) c.ctrl = 4'd0;
            else if (f3 == 4) c.ctrl = 4'd6;
            else if (f3 == 6) c.ctrl = 4'd5;
            else if (f3 == 7) c.ctrl = 4'd4;
            else if (f3 == 1 && f7 == 0) begin c.ctrl = 4'd8; c.b = 32'(sh); end
            else if (f3 == 5 && f7 == 0) begin c.ctrl = 4'd9; c.b = 32'(sh); end
            else if (f3 == 5 && f7 == 'h20) begin c.ctrl = 4'd10; c.b = 32'(sh); end
            else ok = 1'b0;
        end else if (opc == 'h03) begin
            c.a  = rs1;
            c.b  = imm_i;
            c.ld = 1'b1;
            c.f3 = 3'(f3);
            ok   = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        end else if (opc == 'h23) begin
            c.a  = rs1;
            c.b  = imm_s;
            c.st = 1'b1;
            c.f3 = 3'(f3);
            c.sd = rs2;
            ok   = (f3 <= 2);
        end else if (opc == 'h37) begin
            c.b = {inst[31:12], 12'h000};
            ok  = 1'b1;
        end else if (opc == 'h17) begin
            c.a = pc;
            c.b = {inst[31:12], 12'h000};
            ok  = 1'b1;
        end
        if (ok && !c.st && inst[11:7] != 5'd0) begin
            c.we = 1'b1;
            c.rd = inst[11:7];
        end
        return ok;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int kind;
        w    = $urandom;
        kind = $urandom_range(0, 9);
        case (kind)
            0, 1: begin
                w[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            2: begin
                w[6:0] = 7'h13;
                if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            3: w[6:0] = 7'h03;
            4: w[6:0] = 7'h23;
            5: w[6:0] = 7'h37;
            6: w[6:0] = 7'h17;
            7: w[6:0] = 7'h63;
            8: w[6:0] = 7'h6F;
            default: ;
        endcase
        return w;
    endfunction

    cmd_t        q[$];
    bit          ill_exp;
    logic [31:0] ill_inst_exp;

    initial begin
        cmd_t c;
        bit   ok;
        bit   acc;

        // Reset, with a beat presented that must be ignored.
        out_ready = 1'b1;
        drive(1'b1, 32'h002081B3, 32'd9, 32'd9);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, '0, '0, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_illegal", illegal, 1'b0);
        check("rst_illegal_inst", illegal_inst, 32'h0);
        check("rst_sideband", {rd, rd_we, is_load, is_store, mem_funct3, store_data}, '0);

        // Back-to-back legal beats with out_ready high.
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
        tick();
        check("add_valid", out_valid, 1'b1);
        check("add_op_a", op_a, 32'd5);
        check("add_op_b", op_b, 32'd7);
        check("add_ctrl", alu_control, 4'b0000);
        check("add_rd", {rd, rd_we}, {5'd3, 1'b1});
        drive(1'b1, 32'h40335293, 32'h80000000, 32'h0);
        tick();
        check("srai_op_a", op_a, 32'h80000000);
        check("srai_op_b", op_b, 32'd3);
        check("srai_ctrl", alu_control, 4'b1010);
        check("srai_rd", rd, 5'd5);
        drive(1'b1, 32'h123450B7, 32'h55, 32'h0);
        tick();
        check("lui_op_a", op_a, 32'h0);
        check("lui_op_b", op_b, 32'h12345000);
        check("lui_ctrl", alu_control, 4'b0000);
        drive(1'b1, 32'h0020A223, 32'h100, 32'hCAFEF00D);
        tick();
        check("sw_ops", {op_a, op_b}, {32'h100, 32'd4});
        check("sw_flags", {is_store, is_load, mem_funct3}, {1'b1, 1'b0, 3'b010});
        check("sw_data", store_data, 32'hCAFEF00D);
        check("sw_rd", {rd, rd_we}, {5'd0, 1'b0});
        drive(1'b0, '0, '0, '0);
        tick();
        check("idle_out_valid", out_valid, 1'b0);

        // Stall: two beats fill the buffer, the third waits.
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd1, 32'd0);
        tick();
        check("stall1_in_ready", in_ready, 1'b1);
        drive(1'b1, 32'h002081B3, 32'd2, 32'd0);
        tick();
        check("stall2_in_ready", in_ready, 1'b0);
        drive(1'b1, 32'h002081B3, 32'd3, 32'd0);
        tick();
        check("stall3_held", {out_valid, in_ready, op_a}, {1'b1, 1'b0, 32'd1});
        out_ready = 1'b1;
        tick();
        check("drain_beat2", {out_valid, op_a}, {1'b1, 32'd2});
        check("drain_in_ready", in_ready, 1'b1);
        tick();
        check("drain_beat3", {out_valid, op_a}, {1'b1, 32'd3});
        drive(1'b0, '0, '0, '0);
        tick();
        check("drain_empty", out_valid, 1'b0);

        // Illegal SLT: handshake completes, nothing is buffered, one-cycle pulse.
        drive(1'b1, 32'h0020A1B3, 32'd1, 32'd2);
        tick();
        check("slt_pulse", {illegal, out_valid, in_ready}, {1'b1, 1'b0, 1'b1});
        check("slt_inst", illegal_inst, 32'h0020A1B3);
        drive(1'b0, '0, '0, '0);
        tick();
        check("slt_pulse_end", illegal, 1'b0);
        check("slt_inst_hold", illegal_inst, 32'h0020A1B3);

        // Flush with both entries full and an illegal beat presented.
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd11, 32'd0);
        tick();
        drive(1'b1, 32'h002081B3, 32'd12, 32'd0);
        tick();
        check("flush_full", in_ready, 1'b0);
        flush = 1'b1;
        drive(1'b1, 32'h0000A0B3, 32'd13, 32'd0);
        tick();
        check("flush_state", {out_valid, in_ready, illegal}, {1'b0, 1'b1, 1'b0});
        drive(1'b1, 32'h0020A1B3, 32'd0, 32'd0);
        tick();
        check("flush_no_illegal", {illegal, illegal_inst}, {1'b0, 32'h0020A1B3});
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        tick();
        check("flush_dropped", out_valid, 1'b0);

        // Reset in the middle of a stall discards both entries.
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd21, 32'd0);
        tick();
        drive(1'b1, 32'h002081B3, 32'd22, 32'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, '0, '0, '0);
        check("rst_stall", {out_valid, in_ready, illegal_inst}, {1'b0, 1'b1, 32'h0});

        // Randomized traffic against the queue model.
        q.delete();
        ill_exp      = 1'b0;
        ill_inst_exp = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_out_valid", out_valid, q.size() != 0);
            check("rnd_in_ready", in_ready, q.size() < 2);
            check("rnd_illegal", {illegal, illegal_inst}, {ill_exp, ill_inst_exp});
            if (q.size() != 0) check("rnd_cmd", observed(), q[0]);

            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 39) == 0);
            in_inst     = gen_inst();
            in_pc       = $urandom;
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;

            ok  = ref_decode(in_inst, in_pc, in_rs1_data, in_rs2_data, c);
            acc = in_valid && (q.size() < 2) && !flush;
            if (flush) begin
                q.delete();
                ill_exp = 1'b0;
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                ill_exp = acc && !ok;
                if (acc && !ok) ill_inst_exp = in_inst;
                if (acc && ok) q.push_back(c);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
